ifetch_queue: RTL

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue_if.sv | 32 +++
 rtl/ifetch_queue.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: icache fetch handshake plus decoder-side dequeue port.
//   req_valid/req_pc      fetch request, held until the response arrives
//   resp_valid/resp_ins   icache response strobe and fetched word
//   deq_valid/deq_ready   queue head handshake with the decoder
//   deq_ins/deq_pc/deq_pred_pc/deq_is_c   head entry contents
// The master modport is the fetch queue; slave is the icache/decoder side.
interface ifetch_queue_if;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_ins;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_ins;
    logic [31:0] deq_pc;
    logic [31:0] deq_pred_pc;
    logic        deq_is_c;

    modport master (
        output req_valid, req_pc,
        input  resp_valid, resp_ins,
        output deq_valid, deq_ins, deq_pc, deq_pred_pc, deq_is_c,
        input  deq_ready
    );

    modport slave (
        input  req_valid, req_pc,
        output resp_valid, resp_ins,
        input  deq_valid, deq_ins, deq_pc, deq_pred_pc, deq_is_c,
        output deq_ready
    );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch sequencer feeding a circular decode queue.
//   clk_in       system clock
//   rst_in       asynchronous active-low reset
//   rdy_in       global ready; low freezes all state
//   bus          fetch request/response and dequeue handshake (master side)
//   bp_ins/bp_pc current response word and its address, to the predictor
//   pred_pc      predictor next-PC for bp_ins (same cycle)
//   flush_valid/flush_pc   redirect from the ROB, empties the queue
//   jalr_valid/jalr_pc     resolved indirect-jump target
//   q_count      occupied queue entries
module ifetch_queue #(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter bit          RVC_EN      = 1'b1
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    ifetch_queue_if.master               bus,
    output logic [31:0]                  bp_ins,
    output logic [31:0]                  bp_pc,
    input  logic [31:0]                  pred_pc,
    input  logic                         flush_valid,
    input  logic [31:0]                  flush_pc,
    input  logic                         jalr_valid,
    input  logic [31:0]                  jalr_pc,
    output logic [$clog2(QUEUE_DEPTH):0] q_count
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT_RESP, WAIT_JALR} state_t;

    state_t        state, state_d;
    logic [31:0]   pc, pc_d;
    logic          req_valid, req_valid_d;
    logic [31:0]   req_pc, req_pc_d;
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count, count_d;
    logic          enq, pop, clr, full, nonempty;

    logic [31:0] ins_q  [QUEUE_DEPTH];
    logic [31:0] pc_q   [QUEUE_DEPTH];
    logic [31:0] npc_q  [QUEUE_DEPTH];
    logic        c_q    [QUEUE_DEPTH];

    logic [31:0] ins, j_imm, cj_imm, next_pc;
    logic        is_c, is_jal, is_cj, is_jr;

    // Bit 0 of every redirect/prediction is forced to zero, so it is never read.
    logic unused;
    assign unused = ^{pred_pc[0], flush_pc[0], jalr_pc[0]};

    assign ins    = bus.resp_ins;
    assign bp_ins = ins;
    assign bp_pc  = pc;

    // Instruction length and control-flow decode of the response word.
    assign is_c   = RVC_EN && ins[1:0] != 2'b11;
    assign is_jal = ins[6:0] == 7'b1101111;
    // C.J (funct3 101) and C.JAL (funct3 001) share funct3[1:0] == 01.
    assign is_cj  = is_c && ins[1:0] == 2'b01 && ins[14:13] == 2'b01;
    assign is_jr  = ins[6:0] == 7'b1100111 ||
                    (is_c && ins[1:0] == 2'b10 && ins[15:13] == 3'b100 &&
                     ins[11:7] != 5'd0 && ins[6:2] == 5'd0);
    assign j_imm  = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    assign cj_imm = {{20{ins[12]}}, ins[12], ins[8], ins[10:9], ins[6], ins[7],
                     ins[2], ins[11], ins[5:3], 1'b0};

    // Indirect jumps record the fall-through address; the real target comes via jalr_pc.
    assign next_pc = is_jal ? pc + j_imm :
                     is_cj  ? pc + cj_imm :
                     is_jr  ? pc + (is_c ? 32'd2 : 32'd4) :
                              {pred_pc[31:1], 1'b0};

    assign full     = count == CW'(QUEUE_DEPTH);
    assign nonempty = count != '0;
    assign pop      = nonempty && bus.deq_ready && !clr;
    assign count_d  = (enq == pop) ? count : enq ? count + CW'(1) : count - CW'(1);

    always_comb begin
        state_d     = state;
        pc_d        = pc;
        req_valid_d = req_valid;
        req_pc_d    = req_pc;
        enq         = 1'b0;
        clr         = 1'b0;
        if (flush_valid) begin
            state_d     = IDLE;
            pc_d        = {flush_pc[31:1], 1'b0};
            req_valid_d = 1'b0;
            clr         = 1'b1;
        end else begin
            case (state)
                IDLE: if (!full) begin
                    req_valid_d = 1'b1;
                    req_pc_d    = pc;
                    state_d     = WAIT_RESP;
                end
                WAIT_RESP: if (bus.resp_valid) begin
                    req_valid_d = 1'b0;
                    enq         = 1'b1;
                    pc_d        = next_pc;
                    state_d     = is_jr ? WAIT_JALR : IDLE;
                end
                WAIT_JALR: if (jalr_valid) begin
                    pc_d    = {jalr_pc[31:1], 1'b0};
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            req_valid <= 1'b0;
            req_pc    <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else if (rdy_in) begin
            state     <= state_d;
            pc        <= pc_d;
            req_valid <= req_valid_d;
            req_pc    <= req_pc_d;
            head      <= clr ? '0 : pop ? head + AW'(1) : head;
            tail      <= clr ? '0 : enq ? tail + AW'(1) : tail;
            count     <= clr ? '0 : count_d;
        end
    end

    // Entry storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk_in) begin
        if (rdy_in && enq) begin
            ins_q[tail] <= ins;
            pc_q[tail]  <= pc;
            npc_q[tail] <= next_pc;
            c_q[tail]   <= is_c;
        end
    end

    assign bus.req_valid   = req_valid;
    assign bus.req_pc      = req_pc;
    assign bus.deq_valid   = nonempty;
    assign bus.deq_ins     = nonempty ? ins_q[head] : '0;
    assign bus.deq_pc      = nonempty ? pc_q[head] : '0;
    assign bus.deq_pred_pc = nonempty ? npc_q[head] : '0;
    assign bus.deq_is_c    = nonempty && c_q[head];
    assign q_count         = count;
endmodule
